// File: rtl/mac_norm_out_stg_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mac_norm_out_stg_if
// Brief    : Upstream and downstream handshake/data bundle for the MAC
//            normalise/round/pack output stage.
// Revision : 1.0  initial release
// ============================================================================
interface mac_norm_out_stg_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int SUM_W = 16
);
  // upstream side
  logic                     i_clear;
  logic                     i_valid;
  logic                     o_ready;
  logic                     i_sum_sgn;
  logic [SUM_W-1:0]         i_sum_mag;
  logic [EXP_W-1:0]         i_max_exp;
  logic                     i_rnd_mode;
  logic                     i_relu;
  // downstream side
  logic                     o_valid;
  logic                     i_ready;
  logic [EXP_W+MAN_W:0]     o_data;
  logic                     o_ovf;
  logic                     o_udf;

  // the stage itself
  modport slave (
    input  i_clear, i_valid, i_sum_sgn, i_sum_mag, i_max_exp, i_rnd_mode,
           i_relu, i_ready,
    output o_ready, o_valid, o_data, o_ovf, o_udf
  );

  // whoever drives the stage (upstream producer plus downstream consumer)
  modport master (
    output i_clear, i_valid, i_sum_sgn, i_sum_mag, i_max_exp, i_rnd_mode,
           i_relu, i_ready,
    input  o_ready, o_valid, o_data, o_ovf, o_udf
  );
endinterface
`default_nettype wire

// File: rtl/mac_norm_out_stg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mac_norm_out_stg
// Brief    : Final MAC stage. Stage A finds the leading one, the unbiased
//            exponent and the guard/sticky bits; stage B rounds, saturates or
//            flushes, applies ReLU and packs the float word. Elastic 2-entry
//            valid/ready pipeline.
// Revision : 1.0  initial release
// ============================================================================
module mac_norm_out_stg #(
  parameter int EXP_W    = 5,
  parameter int MAN_W    = 10,
  parameter int SUM_W    = 16,
  parameter int FRAC_POS = 10
) (
  input  wire logic          i_clk,
  input  wire logic          i_rst_n,
  mac_norm_out_stg_if.slave  bus
);

  localparam int c_P_W = (SUM_W > 1) ? $clog2(SUM_W) : 1;
  localparam int c_E_W = EXP_W + 2;
  localparam int c_DW  = 1 + EXP_W + MAN_W;
  // bits below the leading one, padded so kept+guard always exist
  localparam int c_X_W = SUM_W + MAN_W + 1;
  localparam logic signed [c_E_W-1:0] c_EXP_OVF  = c_E_W'((1 << EXP_W) - 1);
  localparam logic signed [c_E_W-1:0] c_EXP_ZERO = '0;
  localparam logic [EXP_W-1:0]        c_EXP_SAT  = EXP_W'((1 << EXP_W) - 2);

  // ---------------- handshake ----------------
  logic r_a_valid, r_b_valid;
  logic w_b_load, w_a_load, w_in_xfer;

  assign w_b_load    = !r_b_valid || bus.i_ready;
  assign w_a_load    = !r_a_valid || w_b_load;
  assign w_in_xfer   = bus.i_valid && w_a_load;
  assign bus.o_ready = w_a_load;

  // ---------------- stage A combinational ----------------
  logic [c_P_W-1:0]        w_p;
  logic [SUM_W-1:0]        w_below;
  logic [c_X_W-1:0]        w_ext;
  logic [MAN_W-1:0]        w_man;
  logic                    w_grd, w_stk, w_zero;
  logic signed [c_E_W-1:0] w_exp;

  // leading-one detector: highest set bit wins
  always_comb begin
    w_p = '0;
    for (int i = 0; i < SUM_W; i++) begin
      if (bus.i_sum_mag[i]) w_p = c_P_W'(i);
    end
  end

  // shifting one past the leading one drops the hidden bit and left-aligns the fraction
  assign w_below = bus.i_sum_mag << (SUM_W - int'(w_p));
  assign w_ext   = {w_below, {(MAN_W+1){1'b0}}};
  assign w_man   = w_ext[c_X_W-1 -: MAN_W];
  assign w_grd   = w_ext[c_X_W-1-MAN_W];
  assign w_stk   = |w_ext[c_X_W-2-MAN_W:0];
  assign w_zero  = (bus.i_sum_mag == '0);
  assign w_exp   = c_E_W'(bus.i_max_exp) + c_E_W'(w_p) - c_E_W'(FRAC_POS);

  // ---------------- stage A registers ----------------
  logic                    r_a_sgn, r_a_zero, r_a_grd, r_a_stk, r_a_rnd, r_a_relu;
  logic [MAN_W-1:0]        r_a_man;
  logic signed [c_E_W-1:0] r_a_exp;

  // stage A capture; flush wins over a same-cycle input transfer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_valid <= 1'b0;
      r_a_sgn   <= 1'b0;
      r_a_zero  <= 1'b0;
      r_a_grd   <= 1'b0;
      r_a_stk   <= 1'b0;
      r_a_rnd   <= 1'b0;
      r_a_relu  <= 1'b0;
      r_a_man   <= '0;
      r_a_exp   <= '0;
    end else begin
      if (bus.i_clear)   r_a_valid <= 1'b0;
      else if (w_a_load) r_a_valid <= bus.i_valid;
      if (w_in_xfer) begin
        r_a_sgn  <= bus.i_sum_sgn;
        r_a_zero <= w_zero;
        r_a_grd  <= w_grd;
        r_a_stk  <= w_stk;
        r_a_rnd  <= bus.i_rnd_mode;
        r_a_relu <= bus.i_relu;
        r_a_man  <= w_man;
        r_a_exp  <= w_exp;
      end
    end
  end

  // ---------------- stage B combinational ----------------
  logic                    w_inc, w_carry;
  logic [MAN_W:0]          w_man_sum;
  logic [MAN_W-1:0]        w_man_rnd;
  logic signed [c_E_W-1:0] w_exp_rnd;
  logic [c_DW-1:0]         w_b_data;
  logic                    w_b_ovf, w_b_udf;

  assign w_inc     = !r_a_rnd && r_a_grd && (r_a_stk || r_a_man[0]);
  assign w_man_sum = {1'b0, r_a_man} + (MAN_W+1)'(w_inc);
  assign w_carry   = w_man_sum[MAN_W];
  assign w_man_rnd = w_carry ? '0 : w_man_sum[MAN_W-1:0];
  assign w_exp_rnd = r_a_exp + c_E_W'(w_carry);

  // result select: zero, then ReLU, then overflow, then underflow, then normal
  always_comb begin
    w_b_data = {r_a_sgn, {(c_DW-1){1'b0}}};
    w_b_ovf  = 1'b0;
    w_b_udf  = 1'b0;
    if (r_a_zero) begin
      w_b_data = {r_a_sgn, {(c_DW-1){1'b0}}};
    end else if (r_a_relu && r_a_sgn) begin
      w_b_data = '0;
    end else if (w_exp_rnd >= c_EXP_OVF) begin
      w_b_data = {r_a_sgn, c_EXP_SAT, {MAN_W{1'b1}}};
      w_b_ovf  = 1'b1;
    end else if (w_exp_rnd <= c_EXP_ZERO) begin
      w_b_data = {r_a_sgn, {(c_DW-1){1'b0}}};
      w_b_udf  = 1'b1;
    end else begin
      w_b_data = {r_a_sgn, w_exp_rnd[EXP_W-1:0], w_man_rnd};
    end
  end

  // ---------------- stage B registers ----------------
  logic [c_DW-1:0] r_data;
  logic            r_ovf, r_udf;

  // output register; held while the consumer stalls
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_b_valid <= 1'b0;
      r_data    <= '0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      if (bus.i_clear)   r_b_valid <= 1'b0;
      else if (w_b_load) r_b_valid <= r_a_valid;
      if (w_b_load && r_a_valid) begin
        r_data <= w_b_data;
        r_ovf  <= w_b_ovf;
        r_udf  <= w_b_udf;
      end
    end
  end

  assign bus.o_valid = r_b_valid;
  assign bus.o_data  = r_data;
  assign bus.o_ovf   = r_ovf;
  assign bus.o_udf   = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_mac_norm_out_stg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mac_norm_out_stg
// Brief    : Randomised and directed bench for mac_norm_out_stg with an
//            arithmetic reference model and an in-flight scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_mac_norm_out_stg;
  localparam int EXP_W = 5, MAN_W = 10, SUM_W = 16, FRAC_POS = 10;
  localparam int DW = 1 + EXP_W + MAN_W;
  localparam int RW = DW + 2;
  localparam int ND = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   rdy_mode = 0;
  int   cyc = 0;
  logic [RW-1:0] sb[$];

  mac_norm_out_stg_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .SUM_W(SUM_W)) bus();

  mac_norm_out_stg #(.EXP_W(EXP_W), .MAN_W(MAN_W), .SUM_W(SUM_W), .FRAC_POS(FRAC_POS)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: round the magnitude to MAN_W+1 significant bits with integer arithmetic.
  function automatic logic [RW-1:0] model(input logic [SUM_W-1:0] m, input logic [EXP_W-1:0] ex,
                                          input logic s, input logic r, input logic u);
    int p, sh, e;
    longint q, rem, half;
    logic [RW-1:0] res;
    if (m == 0) return {s, {(DW-1){1'b0}}, 2'b00};
    if (u && s) return '0;
    p = 0;
    for (int i = 0; i < SUM_W; i++) if (m[i]) p = i;
    if (p >= MAN_W) begin
      sh  = p - MAN_W;
      q   = longint'(m) >> sh;
      rem = longint'(m) - (q << sh);
      if (!r && sh > 0) begin
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
      end
    end else begin
      q = longint'(m) << (MAN_W - p);
    end
    e = int'(ex) + p - FRAC_POS;
    if (q == (longint'(1) << (MAN_W + 1))) begin
      q = longint'(1) << MAN_W;
      e = e + 1;
    end
    if (e >= (1 << EXP_W) - 1)
      res = {s, EXP_W'((1 << EXP_W) - 2), {MAN_W{1'b1}}, 2'b10};
    else if (e <= 0)
      res = {s, {(DW-1){1'b0}}, 2'b01};
    else
      res = {s, e[EXP_W-1:0], q[MAN_W-1:0], 2'b00};
    return res;
  endfunction

  // downstream ready pattern: 0 always, 1 toggles 1,0,0,1, 2 random, 3 stalled
  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      case (rdy_mode)
        0:       bus.i_ready = 1'b1;
        1:       bus.i_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        2:       bus.i_ready = 1'($urandom_range(0, 1));
        default: bus.i_ready = 1'b0;
      endcase
    end
  end

  // scoreboard compare: sampled mid-cycle, predicts the coming edge's transfers
  initial begin
    logic prev_stall;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        sb.delete();
        prev_stall = 1'b0;
      end else begin
        check("ready", bus.o_ready, ((sb.size() < 2) || bus.i_ready) ? 1 : 0);
        if (sb.size() == 0) check("no_spurious_valid", bus.o_valid, 0);
        if (sb.size() == 2) check("full_valid", bus.o_valid, 1);
        if (prev_stall) check("held_valid", bus.o_valid, 1);
        if (bus.o_valid && sb.size() > 0)
          check("data", {bus.o_data, bus.o_ovf, bus.o_udf}, sb[0]);
        prev_stall = bus.o_valid && !bus.i_ready;
        if (bus.o_valid && bus.i_ready && sb.size() > 0) void'(sb.pop_front());
        if (bus.i_clear) begin
          sb.delete();
          prev_stall = 1'b0;
        end else if (bus.i_valid && bus.o_ready) begin
          sb.push_back(model(bus.i_sum_mag, bus.i_max_exp, bus.i_sum_sgn,
                             bus.i_rnd_mode, bus.i_relu));
        end
      end
    end
  end

  // present one word and hold it until accepted; returns at the negedge after the transfer
  task automatic send(input logic [SUM_W-1:0] m, input logic [EXP_W-1:0] e,
                      input logic s, input logic r, input logic u);
    int   n;
    logic acc;
    n = 0;
    bus.i_valid = 1'b1;
    bus.i_sum_mag = m;
    bus.i_max_exp = e;
    bus.i_sum_sgn = s;
    bus.i_rnd_mode = r;
    bus.i_relu = u;
    do begin
      #1;
      acc = bus.o_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 200);
    check("send_accept", acc, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.i_valid = 1'b0;
    rdy_mode = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  logic [SUM_W-1:0] t_m[ND] = '{16'h0400, 16'h0400, 16'h0400, 16'h0FFF, 16'h0FFF,
                                16'h8000, 16'h0001, 16'h0000, 16'h8000, 16'h0803,
                                16'h0801, 16'h0800, 16'h0400, 16'h0200, 16'h0400};
  logic [EXP_W-1:0] t_e[ND] = '{5'd15, 5'd15, 5'd15, 5'd15, 5'd15, 5'd30, 5'd3, 5'd15,
                                5'd30, 5'd15, 5'd15, 5'd30, 5'd1, 5'd1, 5'd30};
  logic             t_s[ND] = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
  logic             t_r[ND] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  logic             t_u[ND] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
  logic [DW-1:0]    t_d[ND] = '{16'h3C00, 16'hBC00, 16'h0000, 16'h4400, 16'h43FF,
                                16'h7BFF, 16'h0000, 16'h8000, 16'h0000, 16'h4002,
                                16'h4000, 16'h7BFF, 16'h0400, 16'h0000, 16'h7800};
  logic [1:0]       t_f[ND] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00,
                                2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};

  initial begin
    logic [SUM_W-1:0] m;
    bus.i_clear = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_sum_mag = '0;
    bus.i_max_exp = '0;
    bus.i_sum_sgn = 1'b0;
    bus.i_rnd_mode = 1'b0;
    bus.i_relu = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_valid", bus.o_valid, 0);
    check("rst_data", bus.o_data, 0);
    check("rst_flags", {bus.o_ovf, bus.o_udf}, 0);
    check("rst_ready", bus.o_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // directed vectors: pin the model, then check two-cycle latency and exact word
    for (int i = 0; i < ND; i++) begin
      check($sformatf("model_pin%0d", i), model(t_m[i], t_e[i], t_s[i], t_r[i], t_u[i]),
            {t_d[i], t_f[i]});
      send(t_m[i], t_e[i], t_s[i], t_r[i], t_u[i]);
      bus.i_valid = 1'b0;
      check($sformatf("lat1_valid%0d", i), bus.o_valid, 0);
      @(negedge clk);
      check($sformatf("lat2_valid%0d", i), bus.o_valid, 1);
      check($sformatf("dir_word%0d", i), {bus.o_data, bus.o_ovf, bus.o_udf}, {t_d[i], t_f[i]});
      @(negedge clk);
    end
    drain();

    // back-to-back burst against a 1,0,0,1 consumer
    rdy_mode = 1;
    for (int i = 0; i < 8; i++)
      send(16'($urandom), 5'($urandom_range(5, 25)), 1'($urandom), 1'($urandom), 1'b0);
    drain();

    // flush with two in flight and a competing input
    rdy_mode = 3;
    send(16'h0C00, 5'd14, 1'b0, 1'b0, 1'b0);
    send(16'h0500, 5'd16, 1'b1, 1'b0, 1'b0);
    bus.i_clear = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_sum_mag = 16'h0700;
    @(negedge clk);
    bus.i_clear = 1'b0;
    bus.i_valid = 1'b0;
    check("clear_valid", bus.o_valid, 0);
    rdy_mode = 0;
    send(16'h0600, 5'd12, 1'b0, 1'b0, 1'b0);
    drain();

    // flush beats an input that would otherwise be accepted
    bus.i_clear = 1'b1;
    send(16'h0400, 5'd15, 1'b0, 1'b0, 1'b0);
    bus.i_clear = 1'b0;
    bus.i_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("clear_drop", bus.o_valid, 0);
    end

    // async reset mid-burst
    rdy_mode = 1;
    for (int i = 0; i < 3; i++) send(16'h0400 + 16'(i), 5'd15, 1'b0, 1'b0, 1'b0);
    bus.i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", bus.o_valid, 0);
    check("arst_data", bus.o_data, 0);
    check("arst_ready", bus.o_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    @(negedge clk);
    send(16'h0FFF, 5'd15, 1'b0, 1'b1, 1'b0);
    drain();

    // randomised traffic with random consumer stalls
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       m = 16'($urandom);
        1:       m = 16'($urandom_range(0, 15));
        2:       m = '0;
        default: m = (16'h1 << $urandom_range(0, 15)) | 16'($urandom_range(0, 7));
      endcase
      send(m, 5'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) begin
        bus.i_valid = 1'b0;
        @(negedge clk);
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
